// File: rtl/output_store_control.sv
// Drains systolic-array result rows into the output feature-map BRAM, one element per cycle.
// Latency: a row accepted at edge k is written during cycles k+1..k+Neff (registered write port).
// Backpressure: in_ready is high only while waiting for a row; the source holds row_valid until accepted.
// Optional ReLU clamp on write data is enabled by defining OUTPUT_STORE_RELU_EN.
module output_store_control #(
  parameter int data_size     = 8,
  parameter int array_size    = 9,
  parameter int dim_data_size = 8,
  parameter int addr_size     = 14
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [addr_size-1:0]             initial_address,
  input  logic [dim_data_size-1:0]         output_size,
  input  logic [dim_data_size-1:0]         number_filters,
  input  logic                             row_valid,
  input  logic [array_size*data_size-1:0]  row_data,
  output logic                             in_ready,
  output logic                             mem_we,
  output logic [addr_size-1:0]             mem_addr,
  output logic [data_size-1:0]             mem_wdata,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WRITE, S_DONE} state_t;

  localparam logic [dim_data_size-1:0] ARR_DIM  = dim_data_size'(array_size);
  localparam logic [dim_data_size-1:0] DIM_ONE  = dim_data_size'(1);
  localparam logic [addr_size-1:0]     ADDR_ONE = addr_size'(1);

  state_t                          state_q, state_d;
  logic [addr_size-1:0]            waddr_q, waddr_d;   // next address to write
  logic [dim_data_size-1:0]        neff_q, neff_d;
  logic [dim_data_size-1:0]        nfilt_q, nfilt_d;
  logic [dim_data_size-1:0]        col_q, col_d;
  logic [dim_data_size-1:0]        row_q, row_d;
  logic [dim_data_size-1:0]        filt_q, filt_d;
  logic [array_size*data_size-1:0] buf_q, buf_d;
  logic                            we_q, we_d;
  logic [addr_size-1:0]            addr_q, addr_d;
  logic [data_size-1:0]            wdata_q, wdata_d;

  // Pick element idx of a row; optionally clamp negatives to zero.
  function automatic logic [data_size-1:0] sel_elem(
    input logic [array_size*data_size-1:0] row,
    input logic [dim_data_size-1:0]        idx
  );
    logic [data_size-1:0] e;
    e = '0;
    for (int i = 0; i < array_size; i++) begin
      if (int'(idx) == i) e = row[i*data_size +: data_size];
    end
`ifdef OUTPUT_STORE_RELU_EN
    if (e[data_size-1]) e = '0;
`else
    e = e;
`endif
    return e;
  endfunction

  // Next-state and write-port logic. Addresses are consecutive across columns,
  // rows and filters, so a single running address realises base+f*N*N+r*N+c.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    neff_d  = neff_q;
    nfilt_d = nfilt_q;
    col_d   = col_q;
    row_d   = row_q;
    filt_d  = filt_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          neff_d  = (output_size > ARR_DIM) ? ARR_DIM : output_size;
          nfilt_d = number_filters;
          waddr_d = initial_address;
          col_d   = '0;
          row_d   = '0;
          filt_d  = '0;
          state_d = (number_filters == '0 || output_size == '0) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (row_valid) begin
          buf_d   = row_data;
          we_d    = 1'b1;
          addr_d  = waddr_q;
          waddr_d = waddr_q + ADDR_ONE;
          wdata_d = sel_elem(row_data, '0);
          col_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (col_q == neff_q - DIM_ONE) begin
          if (row_q != neff_q - DIM_ONE) begin
            row_d   = row_q + DIM_ONE;
            state_d = S_CAPTURE;
          end else if (filt_q != nfilt_q - DIM_ONE) begin
            row_d   = '0;
            filt_d  = filt_q + DIM_ONE;
            state_d = S_CAPTURE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          col_d   = col_q + DIM_ONE;
          we_d    = 1'b1;
          addr_d  = waddr_q;
          waddr_d = waddr_q + ADDR_ONE;
          wdata_d = sel_elem(buf_q, col_q + DIM_ONE);
        end
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      neff_q  <= '0;
      nfilt_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      filt_q  <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      neff_q  <= neff_d;
      nfilt_q <= nfilt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      filt_q  <= filt_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready  = (state_q == S_CAPTURE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
